regfile_access_ctrl: RTL and testbench

Initiator-side controller for the 32x32 two-read/one-write register file. It accepts decoded operand requests (rs1, rs2, rd), drives the register file's read port and absorbs its one-cycle synchronous read latency. It forwards writebacks that the register file's read-before-write ordering would miss, and presents operands to execute over a valid/ready handshake. It also owns the write port: it drops writes to x0 and forces x0 reads to zero, which the register file does not do itself.

---
 rtl/regfile_access_ctrl.sv | 172 +++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Operand-fetch controller for the 32x32 2R/1W register file: read issue, latency absorption, x0 handling.
// Optional writeback forwarding and hold snoop are compiled in with REGFILE_FWD_BYPASS_EN.
module regfile_access_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [4:0]  req_rd,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_rs1_data,
  output logic [31:0] op_rs2_data,
  output logic [4:0]  op_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        rf_rd_en,
  output logic [4:0]  rf_rd_addr1,
  output logic [4:0]  rf_rd_addr2,
  input  logic [31:0] rf_rd_data1,
  input  logic [31:0] rf_rd_data2
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic        rst_done_r;
  logic [4:0]  rs1_r, rs2_r, rd_r;
  logic [31:0] op1_r, op2_r, op1_s, op2_s;
  logic        stall_s, issue_s, req_ready_s;

`ifdef REGFILE_FWD_BYPASS_EN
  logic        wbq_valid_r;
  logic [4:0]  wbq_rd_r;
  logic [31:0] wbq_data_r;

  function automatic logic [31:0] resolve_src(
    input logic [4:0]  src,
    input logic [31:0] rf_data,
    input logic        cur_v,
    input logic [4:0]  cur_a,
    input logic [31:0] cur_d,
    input logic        q_v,
    input logic [4:0]  q_a,
    input logic [31:0] q_d
  );
    logic [31:0] res;
    if (src == 5'd0) res = 32'd0;
    else if (cur_v && (cur_a == src)) res = cur_d;
    else if (q_v && (q_a == src)) res = q_d;
    else res = rf_data;
    return res;
  endfunction

  assign stall_s = 1'b0;

  // Remember last cycle's writeback: during FETCH it is the one the read edge missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbq_valid_r <= 1'b0;
      wbq_rd_r    <= 5'd0;
      wbq_data_r  <= 32'd0;
    end else begin
      wbq_valid_r <= wb_valid & (wb_rd != 5'd0);
      wbq_rd_r    <= wb_rd;
      wbq_data_r  <= wb_data;
    end
  end
`else
  function automatic logic [31:0] resolve_src(
    input logic [4:0]  src,
    input logic [31:0] rf_data
  );
    logic [31:0] res;
    if (src == 5'd0) res = 32'd0;
    else res = rf_data;
    return res;
  endfunction

  // Without forwarding, hold off any read that collides with a same-cycle write.
  assign stall_s = wb_valid & (wb_rd != 5'd0) & ((wb_rd == req_rs1) | (wb_rd == req_rs2));
`endif

  assign req_ready_s = rst_done_r & ((state_r == IDLE) | ((state_r == VALID) & op_ready)) & ~stall_s;
  assign issue_s     = req_valid & req_ready_s;

  assign req_ready   = req_ready_s;
  assign rf_rd_en    = issue_s;
  assign rf_rd_addr1 = req_rs1;
  assign rf_rd_addr2 = req_rs2;

  assign rf_wr_en    = wb_valid & (wb_rd != 5'd0);
  assign rf_wr_addr  = wb_rd;
  assign rf_wr_data  = wb_data;

  assign op_valid    = (state_r == VALID);
  assign op_rs1_data = op1_r;
  assign op_rs2_data = op2_r;
  assign op_rd       = rd_r;

  // Next-state and operand-register update.
  always_comb begin
    state_s = state_r;
    op1_s   = op1_r;
    op2_s   = op2_r;
    case (state_r)
      IDLE: begin
        if (issue_s) state_s = FETCH;
        else state_s = IDLE;
      end
      FETCH: begin
        state_s = VALID;
`ifdef REGFILE_FWD_BYPASS_EN
        op1_s = resolve_src(rs1_r, rf_rd_data1, wb_valid, wb_rd, wb_data,
                            wbq_valid_r, wbq_rd_r, wbq_data_r);
        op2_s = resolve_src(rs2_r, rf_rd_data2, wb_valid, wb_rd, wb_data,
                            wbq_valid_r, wbq_rd_r, wbq_data_r);
`else
        op1_s = resolve_src(rs1_r, rf_rd_data1);
        op2_s = resolve_src(rs2_r, rf_rd_data2);
`endif
      end
      VALID: begin
        if (op_ready && issue_s) state_s = FETCH;
        else if (op_ready) state_s = IDLE;
        else state_s = VALID;
`ifdef REGFILE_FWD_BYPASS_EN
        if (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs1_r)) op1_s = wb_data;
        else op1_s = op1_r;
        if (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs2_r)) op2_s = wb_data;
        else op2_s = op2_r;
`endif
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, operand registers and request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rst_done_r <= 1'b0;
      rs1_r      <= 5'd0;
      rs2_r      <= 5'd0;
      rd_r       <= 5'd0;
      op1_r      <= 32'd0;
      op2_r      <= 32'd0;
    end else begin
      state_r    <= state_s;
      rst_done_r <= 1'b1;
      op1_r      <= op1_s;
      op2_r      <= op2_s;
      if (issue_s) begin
        rs1_r <= req_rs1;
        rs2_r <= req_rs2;
        rd_r  <= req_rd;
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed self-checking bench for regfile_access_ctrl with a behavioural 32x32 register file
// (read-before-write, x0 not forced to zero). Covers both REGFILE_FWD_BYPASS_EN builds.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [4:0]  req_rs1 = 5'd0, req_rs2 = 5'd0, req_rd = 5'd0;
  logic        op_valid, op_ready = 1'b0;
  logic [31:0] op_rs1_data, op_rs2_data;
  logic [4:0]  op_rd;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        rf_wr_en, rf_rd_en;
  logic [4:0]  rf_wr_addr, rf_rd_addr1, rf_rd_addr2;
  logic [31:0] rf_wr_data;
  logic [31:0] rf_rd_data1 = 32'd0, rf_rd_data2 = 32'd0;
  logic [31:0] mem [32];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data), .op_rd(op_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_en(rf_rd_en), .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2)
  );

  // Register file model: x0 holds garbage so the controller must zero it.
  always @(posedge clk) begin
    if (rf_rd_en) begin
      rf_rd_data1 <= (rf_rd_addr1 == 5'd0) ? 32'hDEAD_BEEF : mem[rf_rd_addr1];
      rf_rd_data2 <= (rf_rd_addr2 == 5'd0) ? 32'hDEAD_BEEF : mem[rf_rd_addr2];
    end
    if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6;
    #2;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %0b want 0", req_ready); end
    n_tests++; if (rf_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0b want 0", rf_rd_en); end
    n_tests++; if ({op_valid, op_rs1_data, op_rs2_data, op_rd} !== 70'd0) begin n_fail++;
      $display("FAIL reset_outputs: got v=%0b %h %h rd=%0d want all 0", op_valid, op_rs1_data, op_rs2_data, op_rd); end
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step();
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %0b want 1", req_ready); end
  endtask

  task automatic test_write_port();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h11; #1;
    n_tests++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd5, 32'h11}) begin n_fail++;
      $display("FAIL wr_pass: got en=%0b a=%0d d=%h want 1/5/11", rf_wr_en, rf_wr_addr, rf_wr_data); end
    step(); wb_rd = 5'd6; wb_data = 32'h22;
    step(); wb_rd = 5'd9; wb_data = 32'h99;
    step(); wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF; #1;
    n_tests++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL wr_x0_blocked: got %0b want 0", rf_wr_en); end
    step(); wb_valid = 1'b0;
  endtask

  task automatic test_basic_read();
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6; req_rd = 5'd7; op_ready = 1'b1; #1;
    n_tests++; if ({req_ready, rf_rd_en, rf_rd_addr1, rf_rd_addr2} !== {1'b1, 1'b1, 5'd5, 5'd6}) begin n_fail++;
      $display("FAIL basic_issue: got rdy=%0b en=%0b a1=%0d a2=%0d want 1/1/5/6", req_ready, rf_rd_en, rf_rd_addr1, rf_rd_addr2); end
    step(); req_valid = 1'b0;
    n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL basic_fetch_valid: got %0b want 0", op_valid); end
    step();
    n_tests++; if ({op_valid, op_rs1_data, op_rs2_data, op_rd} !== {1'b1, 32'h11, 32'h22, 5'd7}) begin n_fail++;
      $display("FAIL basic_ops: got v=%0b %h %h rd=%0d want 1 11 22 7", op_valid, op_rs1_data, op_rs2_data, op_rd); end
    step();
    n_tests++; if ({op_valid, req_ready} !== 2'b01) begin n_fail++;
      $display("FAIL basic_done: got v=%0b rdy=%0b want 0/1", op_valid, req_ready); end
  endtask

  task automatic test_x0();
    req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd0; req_rd = 5'd1; op_ready = 1'b1;
    step(); req_valid = 1'b0;
    step();
    n_tests++; if ({op_valid, op_rs1_data, op_rs2_data} !== {1'b1, 64'd0}) begin n_fail++;
      $display("FAIL x0_ops: got v=%0b %h %h want 1 0 0", op_valid, op_rs1_data, op_rs2_data); end
    step();
  endtask

  task automatic test_hazard();
    req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd6; req_rd = 5'd4; op_ready = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hABCD; #1;
`ifdef REGFILE_FWD_BYPASS_EN
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL hazard_ready: got %0b want 1", req_ready); end
    step(); wb_valid = 1'b0; req_valid = 1'b0;
`else
    n_tests++; if ({req_ready, rf_rd_en} !== 2'b00) begin n_fail++;
      $display("FAIL hazard_stall: got rdy=%0b en=%0b want 0/0", req_ready, rf_rd_en); end
    step(); wb_valid = 1'b0; #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL hazard_unstall: got %0b want 1", req_ready); end
    step(); req_valid = 1'b0;
`endif
    n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL hazard_fetch: got %0b want 0", op_valid); end
    step();
    n_tests++; if ({op_valid, op_rs1_data, op_rs2_data} !== {1'b1, 32'hABCD, 32'h22}) begin n_fail++;
      $display("FAIL hazard_ops: got v=%0b %h %h want 1 abcd 22", op_valid, op_rs1_data, op_rs2_data); end
    step();
  endtask

  task automatic test_hold();
    logic [31:0] exp_rs2;
`ifdef REGFILE_FWD_BYPASS_EN
    exp_rs2 = 32'h55;
`else
    exp_rs2 = 32'h99;
`endif
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd9; req_rd = 5'd10; op_ready = 1'b0;
    step(); req_valid = 1'b0;
    step();
    n_tests++; if (op_rs2_data !== 32'h99) begin n_fail++; $display("FAIL hold_initial: got %h want 99", op_rs2_data); end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h55; end
      step(); wb_valid = 1'b0;
      n_tests++; if ({op_valid, op_rd, req_ready} !== {1'b1, 5'd10, 1'b0}) begin n_fail++;
        $display("FAIL hold_valid[%0d]: got v=%0b rd=%0d rdy=%0b want 1/10/0", i, op_valid, op_rd, req_ready); end
    end
    n_tests++; if ({op_rs1_data, op_rs2_data} !== {32'h11, exp_rs2}) begin n_fail++;
      $display("FAIL hold_ops: got %h %h want 11 %h", op_rs1_data, op_rs2_data, exp_rs2); end
    op_ready = 1'b1;
    step();
    n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %0b want 0", op_valid); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] pat;
    logic [4:0] seen;
    pat = 5'b10100;
    op_ready = 1'b1;
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6; req_rd = 5'd11; #1;
    seen[0] = op_valid;
    step(); req_rs1 = 5'd6; req_rs2 = 5'd5; req_rd = 5'd12;
    seen[1] = op_valid;
    step();
    seen[2] = op_valid;
    n_tests++; if ({op_rd, req_ready, op_rs1_data} !== {5'd11, 1'b1, 32'h11}) begin n_fail++;
      $display("FAIL b2b_first: got rd=%0d rdy=%0b rs1=%h want 11/1/11", op_rd, req_ready, op_rs1_data); end
    step(); req_valid = 1'b0;
    seen[3] = op_valid;
    step();
    seen[4] = op_valid;
    n_tests++; if (seen !== pat) begin n_fail++; $display("FAIL b2b_pattern: got %b want %b (bit0 first)", seen, pat); end
    n_tests++; if ({op_rd, op_rs1_data, op_rs2_data} !== {5'd12, 32'h22, 32'h11}) begin n_fail++;
      $display("FAIL b2b_second: got rd=%0d %h %h want 12 22 11", op_rd, op_rs1_data, op_rs2_data); end
    step();
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6; req_rd = 5'd13; op_ready = 1'b0;
    step(); req_valid = 1'b0;
    step();
    n_tests++; if (op_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %0b want 1", op_valid); end
    rst_n = 1'b0; #1;
    n_tests++; if ({op_valid, op_rs1_data, op_rs2_data, op_rd, req_ready} !== 71'd0) begin n_fail++;
      $display("FAIL rstmid_clear: got v=%0b %h %h rd=%0d rdy=%0b want 0", op_valid, op_rs1_data, op_rs2_data, op_rd, req_ready); end
    @(negedge clk); rst_n = 1'b1;
    step();
    n_tests++; if ({req_ready, op_valid} !== 2'b10) begin n_fail++;
      $display("FAIL rstmid_release: got rdy=%0b v=%0b want 1/0", req_ready, op_valid); end
  endtask

  initial begin
    test_reset();
    test_write_port();
    test_basic_read();
    test_x0();
    test_hazard();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
